// File: rtl/dmem_wbuf_pkg.sv
// Shared memory-pattern constants and the store lane-steering helpers used by
// the data-memory write buffer.
package dmem_wbuf_pkg;

   localparam logic [3:0] AMP_B0 = 4'b0001;
   localparam logic [3:0] AMP_B1 = 4'b0010;
   localparam logic [3:0] AMP_B2 = 4'b0100;
   localparam logic [3:0] AMP_B3 = 4'b1000;
   localparam logic [3:0] AMP_H0 = 4'b0011;
   localparam logic [3:0] AMP_H1 = 4'b1100;
   localparam logic [3:0] AMP_W  = 4'b1111;

   function automatic logic amp_legal(input logic [3:0] amp);
      case (amp)
         AMP_B0, AMP_B1, AMP_B2, AMP_B3, AMP_H0, AMP_H1, AMP_W: amp_legal = 1'b1;
         default:                                                amp_legal = 1'b0;
      endcase
   endfunction

   // Replicating the low byte/half across the word puts it in every lane;
   // the byte mask then picks the lane(s) that actually get written.
   function automatic logic [31:0] amp_steer(input logic [3:0] amp, input logic [31:0] wd);
      case (amp)
         AMP_B0, AMP_B1, AMP_B2, AMP_B3: amp_steer = {4{wd[7:0]}};
         AMP_H0, AMP_H1:                 amp_steer = {2{wd[15:0]}};
         default:                        amp_steer = wd;
      endcase
   endfunction

endpackage

// File: rtl/dmem_wbuf_fwd.sv
// Store-to-load forwarding: per byte lane, the youngest valid buffered entry
// for the load's word wins; otherwise the lane comes from the array word.
module wbuf_fwd #(
   parameter int DEPTH = 4,
   parameter int IDXW  = 10,
   parameter int XLEN  = 32
) (
   input  logic [$clog2(DEPTH)-1:0] head,
   input  logic                     valid [DEPTH],
   input  logic [IDXW-1:0]          idx   [DEPTH],
   input  logic [XLEN-1:0]          data  [DEPTH],
   input  logic [XLEN/8-1:0]        mask  [DEPTH],
   input  logic [IDXW-1:0]          ld_idx,
   input  logic [XLEN-1:0]          mem_word,
   output logic [XLEN-1:0]          rd
);

   localparam int PW    = $clog2(DEPTH);
   localparam int LANES = XLEN / 8;

   logic [PW-1:0] slot;

   // Walk oldest to youngest so later matches overwrite earlier ones.
   always_comb begin
      rd   = mem_word;
      slot = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + PW'(k);
         for (int b = 0; b < LANES; b++) begin
            if (valid[slot] && idx[slot] == ld_idx && mask[slot][b]) begin
               rd[8*b +: 8] = data[slot][8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dmem_wbuf.sv
// M-stage data memory: posted, coalescing write buffer in front of a word
// array, with same-cycle byte-lane forwarding for loads.
module dmem_wbuf
   import dmem_wbuf_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int MEM_WORDS = 1024,
   parameter int XLEN      = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic                     re,
   input  logic [3:0]               amp,
   input  logic [31:0]              a,
   input  logic [31:0]              wd,
   input  logic                     fence,
   output logic [XLEN-1:0]          rd,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     amperr
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int IDXW  = $clog2(MEM_WORDS);
   localparam int LANES = XLEN / 8;

   logic [IDXW-1:0]  idx_q   [DEPTH];
   logic [XLEN-1:0]  data_q  [DEPTH];
   logic [LANES-1:0] mask_q  [DEPTH];
   logic             valid_q [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW-1:0]    youngest;
   logic [CW-1:0]    count_q;

   logic [XLEN-1:0]  mem [MEM_WORDS];
   logic [XLEN-1:0]  mem_word;
   logic [XLEN-1:0]  fwd_rd;
   logic [XLEN-1:0]  steered;
   logic [IDXW-1:0]  idx;
   logic             legal;
   logic             store;
   logic             load;
   logic             drain;
   logic             coalesce;
   logic             alloc;
   logic             unused_addr;

   assign idx         = a[IDXW+1:2];
   assign unused_addr = ^{a[31:IDXW+2], a[1:0]};
   assign legal       = amp_legal(amp);
   assign steered     = amp_steer(amp, wd);
   assign store       = we & legal;
   assign load        = re & ~we;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign count    = count_q;
   assign youngest = tail - PW'(1);

   // A full buffer with a store arriving always drains, so it cannot overflow.
   assign drain    = !empty && (!re || fence || (full && we));
   assign coalesce = store && !empty && (idx_q[youngest] == idx) &&
                     !(drain && (head == youngest));
   assign alloc    = store && !coalesce;

   // Pointers, valid bits, occupancy and the sticky illegal-pattern flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         amperr  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      end else begin
         if (drain) begin
            valid_q[head] <= 1'b0;
            head          <= head + PW'(1);
         end
         if (alloc) begin
            valid_q[tail] <= 1'b1;
            tail          <= tail + PW'(1);
         end
         count_q <= count_q + CW'(alloc) - CW'(drain);
         if (we && !legal) amperr <= 1'b1;
      end
   end

   // Entry payload needs no reset; the valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (alloc) begin
         idx_q[tail]  <= idx;
         data_q[tail] <= steered;
         mask_q[tail] <= amp;
      end else if (coalesce) begin
         for (int b = 0; b < LANES; b++) begin
            if (amp[b]) begin
               data_q[youngest][8*b +: 8] <= steered[8*b +: 8];
               mask_q[youngest][b]        <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (drain && !reset) begin
         for (int b = 0; b < LANES; b++) begin
            if (mask_q[head][b]) mem[idx_q[head]][8*b +: 8] <= data_q[head][8*b +: 8];
         end
      end
   end

   assign mem_word = mem[idx];

   wbuf_fwd #(
      .DEPTH (DEPTH),
      .IDXW  (IDXW),
      .XLEN  (XLEN)
   ) u_fwd (
      .head     (head),
      .valid    (valid_q),
      .idx      (idx_q),
      .data     (data_q),
      .mask     (mask_q),
      .ld_idx   (idx),
      .mem_word (mem_word),
      .rd       (fwd_rd)
   );

   assign rd = load ? fwd_rd : '0;

endmodule
